// File: rtl/grayscale_stream_ctrl_pkg.sv
// Shared types and helpers for the grayscale stream controller and its luma stage.
package grayscale_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int FLAG_SOF = 0;
    localparam int FLAG_EOL = 1;
    localparam int FLAG_EOF = 2;
    localparam int FLAG_W   = 3;

    function automatic int subpixel_depth(input int pixel_depth);
        return pixel_depth / 3;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grayscale_stream_ctrl_grayscale.sv
// Registered RGB-to-luma stage: truncating shift-add Rec.601 approximation.
module grayscale
    import grayscale_stream_ctrl_pkg::*;
#(
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic                                       I_CLK,
    input  logic                                       I_RESET,
    input  logic                                       I_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0]                   I_PIXEL,
    output logic [subpixel_depth(P_PIXEL_DEPTH)-1:0]   O_PIXEL
);

    localparam int SD = subpixel_depth(P_PIXEL_DEPTH);

    logic [SD-1:0] red, green, blue;
    logic [SD-1:0] luma_d, luma_q;

    assign red   = I_PIXEL[3*SD-1:2*SD];
    assign green = I_PIXEL[2*SD-1:SD];
    assign blue  = I_PIXEL[SD-1:0];

    // Coefficients 0.297 / 0.586 / 0.109; the sum stays below full scale, so no carry out.
    assign luma_d = (red >> 2) + (red >> 5) + (red >> 6)
                  + (green >> 1) + (green >> 4) + (green >> 6) + (green >> 7)
                  + (blue >> 4) + (blue >> 5) + (blue >> 6);

    always_ff @(posedge I_CLK) begin
        if (I_ENABLE) begin
            luma_q <= I_RESET ? '0 : luma_d;
        end
    end

    assign O_PIXEL = luma_q;

endmodule

// File: rtl/grayscale_stream_ctrl.sv
// Frame sequencer around the grayscale stage: handshake, position counters and frame flags.
// state | meaning
// IDLE  | waiting for I_START
// RUN   | accepting pixels, counting col/row
// FLUSH | last pixel accepted, waiting for it to drain
module grayscale_stream_ctrl
    import grayscale_stream_ctrl_pkg::*;
#(
    parameter int P_PIXEL_DEPTH  = 24,
    parameter int P_IMAGE_WIDTH  = 640,
    parameter int P_IMAGE_HEIGHT = 480
) (
    input  logic                                       I_CLK,
    input  logic                                       I_RESET,
    input  logic                                       I_START,
    input  logic                                       I_VALID,
    input  logic [P_PIXEL_DEPTH-1:0]                   I_PIXEL,
    output logic                                       O_READY,
    output logic                                       O_VALID,
    input  logic                                       I_READY,
    output logic [subpixel_depth(P_PIXEL_DEPTH)-1:0]   O_PIXEL,
    output logic                                       O_SOF,
    output logic                                       O_EOL,
    output logic                                       O_EOF,
    output logic                                       O_BUSY,
    output logic                                       O_DONE
);

    localparam int CW = cnt_width(P_IMAGE_WIDTH);
    localparam int RW = cnt_width(P_IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(P_IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(P_IMAGE_HEIGHT - 1);

    state_t              state_q;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic                valid_q;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                busy_q;
    logic                done_q;

    logic stage_en, accept, drain, col_last, row_last, gray_en;

    assign stage_en = ~valid_q | I_READY;
    assign O_READY  = (state_q == ST_RUN) & stage_en;
    assign accept   = I_VALID & O_READY;
    assign drain    = valid_q & I_READY;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign gray_en  = stage_en | I_RESET;

    always_comb begin
        flags_d           = '0;
        flags_d[FLAG_SOF] = (col_q == '0) & (row_q == '0);
        flags_d[FLAG_EOL] = col_last;
        flags_d[FLAG_EOF] = col_last & row_last;
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stage_en) begin
                valid_q <= accept;
                flags_q <= accept ? flags_d : '0;
            end
            case (state_q)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is deliberately dropped.
                    if (I_START && !done_q) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (col_last && row_last) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (drain) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    grayscale #(
        .P_PIXEL_DEPTH(P_PIXEL_DEPTH)
    ) u_grayscale (
        .I_CLK    (I_CLK),
        .I_RESET  (I_RESET),
        .I_ENABLE (gray_en),
        .I_PIXEL  (I_PIXEL),
        .O_PIXEL  (O_PIXEL)
    );

    assign O_VALID = valid_q;
    assign O_SOF   = flags_q[FLAG_SOF];
    assign O_EOL   = flags_q[FLAG_EOL];
    assign O_EOF   = flags_q[FLAG_EOF];
    assign O_BUSY  = busy_q;
    assign O_DONE  = done_q;

endmodule

// File: tb/tb_grayscale_stream_ctrl.sv
// Scoreboard bench: a 4x2 instance for directed frames and a 640x32 instance for a long random-gap frame.
module tb_grayscale_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, valid_i, ready_i, sel;
    logic [23:0] pixel_i;

    logic       s_ready, s_valid, s_sof, s_eol, s_eof, s_busy, s_done;
    logic [7:0] s_pix;
    logic       l_ready, l_valid, l_sof, l_eol, l_eof, l_busy, l_done;
    logic [7:0] l_pix;

    grayscale_stream_ctrl #(.P_PIXEL_DEPTH(24), .P_IMAGE_WIDTH(4), .P_IMAGE_HEIGHT(2)) dut_s (
        .I_CLK(clk), .I_RESET(rst), .I_START(start & ~sel), .I_VALID(valid_i), .I_PIXEL(pixel_i),
        .O_READY(s_ready), .O_VALID(s_valid), .I_READY(ready_i), .O_PIXEL(s_pix),
        .O_SOF(s_sof), .O_EOL(s_eol), .O_EOF(s_eof), .O_BUSY(s_busy), .O_DONE(s_done)
    );

    grayscale_stream_ctrl #(.P_PIXEL_DEPTH(24), .P_IMAGE_WIDTH(640), .P_IMAGE_HEIGHT(32)) dut_l (
        .I_CLK(clk), .I_RESET(rst), .I_START(start & sel), .I_VALID(valid_i), .I_PIXEL(pixel_i),
        .O_READY(l_ready), .O_VALID(l_valid), .I_READY(ready_i), .O_PIXEL(l_pix),
        .O_SOF(l_sof), .O_EOL(l_eol), .O_EOF(l_eof), .O_BUSY(l_busy), .O_DONE(l_done)
    );

    logic       m_ready, m_valid, m_sof, m_eol, m_eof, m_busy, m_done;
    logic [7:0] m_pix;
    assign m_ready = sel ? l_ready : s_ready;
    assign m_valid = sel ? l_valid : s_valid;
    assign m_sof   = sel ? l_sof   : s_sof;
    assign m_eol   = sel ? l_eol   : s_eol;
    assign m_eof   = sel ? l_eof   : s_eof;
    assign m_busy  = sel ? l_busy  : s_busy;
    assign m_done  = sel ? l_done  : s_done;
    assign m_pix   = sel ? l_pix   : s_pix;

    typedef struct {
        logic [7:0] pix;
        logic       sof, eol, eof;
    } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0;
    int W, H, acc, bc, br, outs, n_sof, n_eol, n_eof, n_done, cyc, eof_cyc, done_cyc;
    int stall_at = 0, abort_at = 0;
    bit start_mid = 0, start_at_done = 0, pend_valid = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] luma(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return 8'(r/4 + r/32 + r/64 + g/2 + g/16 + g/64 + g/128 + b/16 + b/32 + b/64);
    endfunction

    function automatic logic [23:0] pix_of(input int k, input int mode);
        if (mode == 0) return 24'hFFFFFF;
        if (mode == 1) begin
            case (k % 4)
                0:       return 24'hFF0000;
                1:       return 24'h00FF00;
                2:       return 24'h0000FF;
                default: return 24'h000000;
            endcase
        end
        return 24'($urandom);
    endfunction

    // One clock: settle, score drain and accept, then advance past the edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (pend_valid) chk("latency", 32'(m_valid), 32'd1);
        pend_valid = 0;
        if (m_valid && ready_i) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(m_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("out", 32'({m_pix, m_sof, m_eol, m_eof}), 32'({e.pix, e.sof, e.eol, e.eof}));
                outs++;
                if (m_sof) n_sof++;
                if (m_eol) n_eol++;
                if (m_eof) n_eof++;
                if (e.eof) eof_cyc = cyc;
            end
        end
        if (valid_i && m_ready) begin
            e.pix = luma(pixel_i);
            e.sof = (bc == 0) && (br == 0);
            e.eol = (bc == W - 1);
            e.eof = e.eol && (br == H - 1);
            q.push_back(e);
            pend_valid = 1;
            acc++;
            if (bc == W - 1) begin
                bc = 0;
                br++;
            end else begin
                bc++;
            end
        end
        if (m_done) begin
            n_done++;
            done_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input int pv, input int pr, input int mode);
        int guard;
        logic [10:0] hold;
        acc = 0; bc = 0; br = 0; outs = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_done = 0;
        eof_cyc = -100; done_cyc = 0;
        valid_i = 0; ready_i = 1; start = 1;
        cycle();
        start = 0;
        chk("busy_after_start", 32'(m_busy), 32'd1);
        guard = 0;
        while (acc < n && guard < 150000) begin
            if (abort_at > 0 && acc == abort_at) begin
                rst = 1; valid_i = 0;
                @(posedge clk);
                #1;
                rst = 0;
                chk("rst_valid", 32'(m_valid), 32'd0);
                chk("rst_busy", 32'(m_busy), 32'd0);
                chk("rst_pixel", 32'(m_pix), 32'd0);
                chk("rst_ready", 32'(m_ready), 32'd0);
                chk("rst_flags_done", 32'({m_sof, m_eol, m_eof, m_done}), 32'd0);
                q.delete();
                pend_valid = 0;
                return;
            end
            valid_i = ($urandom_range(99) < pv);
            ready_i = ($urandom_range(99) < pr);
            pixel_i = pix_of(acc, mode);
            start   = start_mid && (acc == 3);
            if (stall_at > 0 && acc == stall_at && m_valid) begin
                stall_at = 0;
                ready_i = 0;
                valid_i = 1;
                hold = {m_pix, m_sof, m_eol, m_eof};
                repeat (3) begin
                    cycle();
                    chk("stall_ready", 32'(m_ready), 32'd0);
                    chk("stall_hold", 32'({m_valid, m_pix, m_sof, m_eol, m_eof}), 32'({1'b1, hold}));
                end
                ready_i = 1;
                continue;
            end
            cycle();
            guard++;
        end
        start = 0; valid_i = 0;
        chk("accept_timeout", 32'(acc), 32'(n));
        guard = 0;
        while (!m_done && guard < 1000) begin
            ready_i = ($urandom_range(99) < pr);
            start = start_mid && (guard == 0);
            cycle();
            start = 0;
            guard++;
        end
        chk("done_timeout", 32'(m_done), 32'd1);
        start = start_at_done;
        cycle();
        start = 0;
        if (start_at_done) chk("start_at_done", 32'(m_busy), 32'd0);
        repeat (3) cycle();
        chk("busy_idle", 32'(m_busy), 32'd0);
        chk("out_count", 32'(outs), 32'(n));
        chk("sof_count", 32'(n_sof), 32'd1);
        chk("eol_count", 32'(n_eol), 32'(H));
        chk("eof_count", 32'(n_eof), 32'd1);
        chk("done_count", 32'(n_done), 32'd1);
        chk("done_latency", 32'(done_cyc - eof_cyc), 32'd1);
        chk("queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1; start = 0; valid_i = 0; ready_i = 0; pixel_i = '0; sel = 0; cyc = 0;
        W = 4; H = 2;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("reset_outs", 32'({m_valid, m_sof, m_eol, m_eof, m_busy, m_done, m_ready}), 32'd0);
        chk("reset_pixel", 32'(m_pix), 32'd0);

        feed(8, 100, 100, 0);
        feed(8, 100, 100, 1);
        stall_at = 2;
        feed(8, 100, 100, 0);
        start_mid = 1; start_at_done = 1;
        feed(8, 100, 100, 2);
        start_mid = 0; start_at_done = 0;
        abort_at = 3;
        feed(8, 100, 100, 0);
        abort_at = 0;
        feed(8, 100, 100, 0);
        feed(8, 60, 60, 2);

        sel = 1; W = 640; H = 32;
        feed(640 * 32, 70, 70, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
